// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line timing,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

  localparam int unsigned BPS_DEF             = 9600;
  localparam int unsigned CLK_FRE_DEF         = 50_000_000;
  localparam int unsigned CNT_BIT_CLK_MAX_DEF = CLK_FRE_DEF / BPS_DEF;
  localparam int unsigned BAUD_CNT_W          = 13;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchroniser for an asynchronous, idle-high input, with a
// falling-edge strobe taken between the second and third stages.
module sync_edge (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic rx_s1;
  logic rx_s2;
  logic rx_s3;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= din;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign dout = rx_s2;
  assign fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-bit qualification at mid bit, LSB-first data
// capture, stop-bit check with frame-error pulse and break hold-off.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BPS             = BPS_DEF,
  parameter int unsigned CLK_FRE         = CLK_FRE_DEF,
  parameter int unsigned CNT_BIT_CLK_MAX = CLK_FRE / BPS
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [BAUD_CNT_W-1:0] HALF_M1 = BAUD_CNT_W'(CNT_BIT_CLK_MAX / 2 - 1);
  localparam logic [BAUD_CNT_W-1:0] BIT_M1  = BAUD_CNT_W'(CNT_BIT_CLK_MAX - 1);

  uart_state_t           state;
  uart_state_t           state_nxt;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_reg;
  logic                  rx_s2;
  logic                  rx_fall;
  logic                  sample_bit;
  logic                  stop_ok;
  logic                  stop_bad;

  sync_edge u_sync_edge (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (rx),
    .dout      (rx_s2),
    .fall      (rx_fall)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fall) state_nxt = START;
      end
      START: begin
        // A line that is high again at mid start bit was a glitch.
        if (baud_cnt == HALF_M1) state_nxt = rx_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (baud_cnt == BIT_M1) begin
          sample_bit = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == BIT_M1) begin
          stop_ok   = rx_s2;
          stop_bad  = ~rx_s2;
          state_nxt = rx_s2 ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s2) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every sample point either changes state or is a data sample, so these
  // two conditions cover all counter restarts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt <= '0;
    end else if (state == IDLE || state_nxt != state || sample_bit) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state != DATA) begin
      bit_cnt <= '0;
    end else if (sample_bit) begin
      shift_reg[bit_cnt] <= rx_s2;
      bit_cnt            <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      po_data   <= '0;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag   <= stop_ok;
      frame_err <= stop_bad;
      if (stop_ok) po_data <= shift_reg;
    end
  end

  assign rx_busy = (state != IDLE);

endmodule
